// File: rtl/uart_alu_sequencer_pkg.sv
// uart_alu_sequencer_pkg: shared FSM states, width helpers and ALU opcodes
package uart_alu_sequencer_pkg;
  typedef enum logic [2:0] {RECV_A, RECV_B, RECV_OP, LATCH, SEND, WAIT_DONE} state_e;
  localparam int N_BITS_DEF        = 8;
  localparam int N_WORD_BYTES_DEF  = 2;
  localparam int TIMEOUT_TICKS_DEF = 704;
  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_NOR = 8'h27;
  function automatic int word_w(input int n_bits, input int n_bytes);
    return n_bits * n_bytes;
  endfunction
  function automatic int idx_w(input int n_bytes);
    return $clog2(n_bytes + 1);
  endfunction
  function automatic int tmo_w(input int ticks);
    return $clog2(ticks + 1);
  endfunction
endpackage

// File: rtl/uart_byte_assembler.sv
// uart_byte_assembler: little-endian multi-byte operand shadow register
//   clk, reset : clock, sync active-high reset
//   clr_i      : discard partial word (index and shadow to 0)
//   wr_i       : byte strobe for this operand, byte_i its data
//   word_o     : shadow word; busy_o: partial word held; last_o: final byte written now
module uart_byte_assembler
  import uart_alu_sequencer_pkg::*;
#(
  parameter int N_BITS       = N_BITS_DEF,
  parameter int N_WORD_BYTES = N_WORD_BYTES_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clr_i,
  input  logic                           wr_i,
  input  logic [N_BITS-1:0]              byte_i,
  output logic [N_BITS*N_WORD_BYTES-1:0] word_o,
  output logic                           busy_o,
  output logic                           last_o
);
  localparam int W  = word_w(N_BITS, N_WORD_BYTES);
  localparam int IW = idx_w(N_WORD_BYTES);
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  word_q, word_d;
  assign word_o = word_q;
  assign busy_o = idx_q != '0;
  assign last_o = wr_i && idx_q == IW'(N_WORD_BYTES - 1);
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clr_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (wr_i) begin
      word_d[idx_q*N_BITS +: N_BITS] = byte_i;
      idx_d = last_o ? '0 : idx_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end
endmodule

// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: UART command sequencer (A, B, opcode in; result bytes out)
//   clk, reset          : clock, sync active-high reset
//   i_tick              : baud tick, drives the inter-byte timeout
//   i_dato_Recv(_valid) : received byte and its strobe
//   o_A, o_B, o_OP      : operands/opcode of last completed command, i_res: ALU result
//   o_tx_start/o_tx_data/i_tx_done : byte-wise transmit handshake
//   o_busy, o_timeout   : command/response in progress, partial command discarded
//   Macro RESP_CHECKSUM_EN appends an XOR checksum frame to each response.
module uart_alu_sequencer
  import uart_alu_sequencer_pkg::*;
#(
  parameter int N_BITS        = N_BITS_DEF,
  parameter int N_WORD_BYTES  = N_WORD_BYTES_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_tick,
  input  logic [N_BITS-1:0]              i_dato_Recv,
  input  logic                           i_dato_Recv_valid,
  output logic [N_BITS*N_WORD_BYTES-1:0] o_A,
  output logic [N_BITS*N_WORD_BYTES-1:0] o_B,
  output logic [N_BITS-1:0]              o_OP,
  input  logic [N_BITS*N_WORD_BYTES-1:0] i_res,
  output logic                           o_tx_start,
  output logic [N_BITS-1:0]              o_tx_data,
  input  logic                           i_tx_done,
  output logic                           o_busy,
  output logic                           o_timeout
);
  localparam int W  = word_w(N_BITS, N_WORD_BYTES);
  localparam int IW = idx_w(N_WORD_BYTES);
  localparam int TW = tmo_w(TIMEOUT_TICKS);
`ifdef RESP_CHECKSUM_EN
  localparam int LAST_IDX = N_WORD_BYTES;
`else
  localparam int LAST_IDX = N_WORD_BYTES - 1;
`endif
  state_e        state_q, state_d;
  logic [IW-1:0] tx_idx_q, tx_idx_d;
  logic [W-1:0]  res_q, res_d, a_sh, b_sh;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [N_BITS-1:0] tx_byte;
  logic timeout_q, wr_a, wr_b, wr_op, accept, rx_busy, expire;
  logic a_busy, b_busy, a_last, b_last, tx_phase;
  assign wr_a     = i_dato_Recv_valid && state_q == RECV_A;
  assign wr_b     = i_dato_Recv_valid && state_q == RECV_B;
  assign wr_op    = i_dato_Recv_valid && state_q == RECV_OP;
  assign accept   = wr_a || wr_b || wr_op;
  assign rx_busy  = a_busy || b_busy || state_q == RECV_B || state_q == RECV_OP;
  assign tx_phase = state_q == SEND || state_q == WAIT_DONE;
  // a byte landing on the expiry tick is accepted instead of timing out
  assign expire   = rx_busy && i_tick && !accept && tmo_q == TW'(TIMEOUT_TICKS - 1);
  assign tmo_d    = (accept || expire) ? '0 : (rx_busy && i_tick) ? tmo_q + 1'b1 : tmo_q;
  uart_byte_assembler #(.N_BITS(N_BITS), .N_WORD_BYTES(N_WORD_BYTES)) u_asm_a (
    .clk(clk), .reset(reset), .clr_i(expire), .wr_i(wr_a), .byte_i(i_dato_Recv),
    .word_o(a_sh), .busy_o(a_busy), .last_o(a_last)
  );
  uart_byte_assembler #(.N_BITS(N_BITS), .N_WORD_BYTES(N_WORD_BYTES)) u_asm_b (
    .clk(clk), .reset(reset), .clr_i(expire), .wr_i(wr_b), .byte_i(i_dato_Recv),
    .word_o(b_sh), .busy_o(b_busy), .last_o(b_last)
  );
`ifdef RESP_CHECKSUM_EN
  logic [N_BITS-1:0] csum_q, res_xor;
  always_comb begin
    res_xor = '0;
    for (int i = 0; i < N_WORD_BYTES; i++) res_xor = res_xor ^ i_res[i*N_BITS +: N_BITS];
  end
  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else if (state_q == LATCH) csum_q <= res_xor;
  end
  assign tx_byte = (tx_idx_q == IW'(N_WORD_BYTES)) ? csum_q : res_q[N_BITS-1:0];
`else
  assign tx_byte = res_q[N_BITS-1:0];
`endif
  assign o_tx_start = state_q == SEND;
  assign o_tx_data  = tx_phase ? tx_byte : '0;
  assign o_busy     = rx_busy || tx_phase || state_q == LATCH;
  assign o_timeout  = timeout_q;
  // the result register shifts down one byte per completed frame
  always_comb begin
    state_d  = state_q;
    tx_idx_d = tx_idx_q;
    res_d    = res_q;
    if (expire) state_d = RECV_A;
    else case (state_q)
      RECV_A:  state_d = a_last ? RECV_B : RECV_A;
      RECV_B:  state_d = b_last ? RECV_OP : RECV_B;
      RECV_OP: state_d = wr_op ? LATCH : RECV_OP;
      LATCH: begin
        res_d    = i_res;
        tx_idx_d = '0;
        state_d  = SEND;
      end
      SEND:    state_d = WAIT_DONE;
      WAIT_DONE: if (i_tx_done) begin
        tx_idx_d = tx_idx_q + 1'b1;
        res_d    = res_q >> N_BITS;
        state_d  = (tx_idx_q == IW'(LAST_IDX)) ? RECV_A : SEND;
      end
      default: state_d = RECV_A;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RECV_A;
      tx_idx_q  <= '0;
      res_q     <= '0;
      tmo_q     <= '0;
      timeout_q <= 1'b0;
      o_A       <= '0;
      o_B       <= '0;
      o_OP      <= '0;
    end else begin
      state_q   <= state_d;
      tx_idx_q  <= tx_idx_d;
      res_q     <= res_d;
      tmo_q     <= tmo_d;
      timeout_q <= expire;
      if (wr_op) begin
        o_A  <= a_sh;
        o_B  <= b_sh;
        o_OP <= i_dato_Recv;
      end
    end
  end
endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb_uart_alu_sequencer: scoreboard bench with ALU model and uart_tx responder
module tb_uart_alu_sequencer;
  import uart_alu_sequencer_pkg::*;
  logic clk = 0, reset = 1, i_tick = 0, i_dato_Recv_valid = 0, i_tx_done = 0;
  logic [7:0] i_dato_Recv = 0, o_OP, o_tx_data, got;
  logic [15:0] o_A, o_B, i_res;
  logic o_tx_start, o_busy, o_timeout, tx_auto = 1;
  logic [7:0] exp_q[$];
  int n_checks = 0, n_err = 0, n_to = 0, n_start = 0, s;
  uart_alu_sequencer dut (
    .clk(clk), .reset(reset), .i_tick(i_tick), .i_dato_Recv(i_dato_Recv),
    .i_dato_Recv_valid(i_dato_Recv_valid), .o_A(o_A), .o_B(o_B), .o_OP(o_OP),
    .i_res(i_res), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .i_tx_done(i_tx_done), .o_busy(o_busy), .o_timeout(o_timeout)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] alu(input logic [15:0] a, b, input logic [7:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return $signed(a) >>> b;
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return '0;
    endcase
  endfunction
  assign i_res = alu(o_A, o_B, o_OP);
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (o_timeout) n_to++;
    if (o_tx_start) n_start++;
  end
  initial forever begin
    @(negedge clk);
    if (tx_auto) i_tx_done = 0;
    if (o_tx_start && tx_auto) begin
      got = o_tx_data;
      if (exp_q.size() > 0) check("tx_byte", got, exp_q.pop_front());
      repeat (3) @(negedge clk);
      check("tx_hold", o_tx_data, got);
      i_tx_done = 1;
    end
  end
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_dato_Recv = b;
    i_dato_Recv_valid = 1;
    @(negedge clk);
    i_dato_Recv_valid = 0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_tick = 1;
      @(negedge clk);
      i_tick = 0;
    end
  endtask
  task automatic push_resp(input logic [15:0] r);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
`ifdef RESP_CHECKSUM_EN
    exp_q.push_back(r[7:0] ^ r[15:8]);
`endif
  endtask
  task automatic send_cmd(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(b[7:0]);
    send_byte(b[15:8]);
    send_byte(op);
  endtask
  task automatic wait_idle(input string tag);
    int k = 0;
    while ((o_busy || exp_q.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_left"}, exp_q.size(), 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    check("rst_A", o_A, 0);
    check("rst_OP", o_OP, 0);
    check("rst_busy", o_busy, 0);
    check("rst_start", o_tx_start, 0);
    push_resp(16'h1245);
    send_cmd(16'h1234, 16'h0011, OP_ADD);
    check("add_A", o_A, 16'h1234);
    check("add_B", o_B, 16'h0011);
    check("add_OP", o_OP, OP_ADD);
    check("add_lat1", o_tx_start, 0);
    @(negedge clk);
    check("add_lat2", o_tx_start, 1);
    wait_idle("add");
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h11);
    s = n_to;
    ticks(703);
    @(negedge clk);
    check("to_early", n_to, s);
    check("to_busy", o_busy, 1);
    ticks(1);
    @(negedge clk);
    check("to_pulse", n_to, s + 1);
    check("to_idle", o_busy, 0);
    check("to_A", o_A, 16'h1234);
    check("to_B", o_B, 16'h0011);
    push_resp(16'h0002);
    send_cmd(16'h0005, 16'h0003, OP_SUB);
    check("sub_A", o_A, 16'h0005);
    wait_idle("sub");
    s = n_to;
    send_byte(8'h05);
    ticks(703);
    @(negedge clk);
    i_tick = 1;
    i_dato_Recv = 8'h00;
    i_dato_Recv_valid = 1;
    @(negedge clk);
    i_tick = 0;
    i_dato_Recv_valid = 0;
    @(negedge clk);
    check("race_to", n_to, s);
    check("race_busy", o_busy, 1);
    push_resp(16'h0006);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(OP_XOR);
    check("race_A", o_A, 16'h0005);
    wait_idle("race");
    push_resp(16'h000F);
    send_cmd(16'h00FF, 16'h0F0F, OP_AND);
    @(negedge clk);
    send_byte(8'hAA);
    send_byte(8'hBB);
    wait_idle("drop");
    check("drop_A", o_A, 16'h00FF);
    push_resp(16'h1234);
    send_cmd(16'h1200, 16'h0034, OP_OR);
    check("or_B", o_B, 16'h0034);
    wait_idle("or");
    tx_auto = 0;
    s = n_start;
    @(negedge clk);
    i_tx_done = 1;
    @(negedge clk);
    i_tx_done = 0;
    repeat (3) @(negedge clk);
    check("stray_done_busy", o_busy, 0);
    check("stray_done_start", n_start, s);
    send_cmd(16'h1234, 16'h00FF, OP_XOR);
    for (int k = 0; k < 50 && !o_tx_start; k++) @(negedge clk);
    check("rst_tx_start", o_tx_start, 1);
    check("rst_tx_b0", o_tx_data, 8'hCB);
    repeat (2) @(negedge clk);
    i_tx_done = 1;
    reset = 1;
    @(negedge clk);
    i_tx_done = 0;
    reset = 0;
    check("mid_A", o_A, 0);
    check("mid_B", o_B, 0);
    check("mid_OP", o_OP, 0);
    check("mid_data", o_tx_data, 0);
    check("mid_busy", o_busy, 0);
    check("mid_to", o_timeout, 0);
    s = n_start;
    repeat (20) @(negedge clk);
    check("mid_nostart", n_start, s);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
